lif_neuron_array: RTL and testbench

Time-multiplexed array of parametrised leaky integrate-and-fire neurons that sit behind the top-level pin wrapper and drive its spike outputs. A single shared update datapath serves every neuron in round-robin order, one neuron per enabled cycle. Each neuron has saturating membrane arithmetic, a run-time threshold, a selectable post-spike reset mode and a refractory period. The previous single-neuron block had neither run-time configuration nor refractory behaviour.

---
 rtl/lif_pkg.sv | 25 ++
 rtl/lif_update.sv | 54 +++++
 rtl/lif_neuron_array.sv | 96 +++++++++
 tb/tb_lif_neuron_array.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// lif_pkg: shared constants and helpers for the LIF neuron array.
// Rev 1.0
`default_nettype none

package lif_pkg;

   localparam int DEF_N_NEURONS      = 3;
   localparam int DEF_V_WIDTH        = 8;
   localparam int DEF_I_WIDTH        = 8;
   localparam int DEF_LEAK_SHIFT     = 1;
   localparam int DEF_REFRAC_UPDATES = 2;

   localparam logic RST_ZERO = 1'b0;
   localparam logic RST_SUB  = 1'b1;

   // Register widths must never collapse to zero bits, even for degenerate counts.
   function automatic int clog2_min1(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

`default_nettype wire

// File: rtl/lif_update.sv
// lif_update: combinational leak / integrate / saturate / fire datapath for one neuron.
// Rev 1.0
`default_nettype none

module lif_update
   import lif_pkg::*;
#(
   parameter int V_WIDTH        = DEF_V_WIDTH,
   parameter int I_WIDTH        = DEF_I_WIDTH,
   parameter int LEAK_SHIFT     = DEF_LEAK_SHIFT,
   parameter int REFRAC_UPDATES = DEF_REFRAC_UPDATES,
   parameter int R_WIDTH        = clog2_min1(REFRAC_UPDATES + 1)
) (
   input  logic [V_WIDTH-1:0] v,
   input  logic [R_WIDTH-1:0] r,
   input  logic [I_WIDTH-1:0] isyn_i,
   input  logic [V_WIDTH-1:0] threshold,
   input  logic               reset_mode,
   output logic [V_WIDTH-1:0] v_next,
   output logic [R_WIDTH-1:0] r_next,
   output logic               fire
);

   localparam logic [R_WIDTH-1:0] REFRAC_LOAD = R_WIDTH'(REFRAC_UPDATES);
   localparam logic [V_WIDTH-1:0] V_MAX       = {V_WIDTH{1'b1}};

   logic [V_WIDTH-1:0] w_leaked;
   logic [V_WIDTH:0]   w_sum;
   logic [V_WIDTH-1:0] w_sat;
   logic               w_cross;

   assign w_leaked = v - (v >> LEAK_SHIFT);
   assign w_sum    = {1'b0, w_leaked} + (V_WIDTH + 1)'(isyn_i);
   assign w_sat    = w_sum[V_WIDTH] ? V_MAX : w_sum[V_WIDTH-1:0];
   assign w_cross  = (w_sat >= threshold);

   always_comb begin
      v_next = w_sat;
      r_next = r;
      fire   = 1'b0;
      if (r != '0) begin
         // Refractory updates discard input and clear any residual charge.
         v_next = '0;
         r_next = r - R_WIDTH'(1);
      end else if (w_cross) begin
         fire   = 1'b1;
         r_next = REFRAC_LOAD;
         v_next = (reset_mode == RST_SUB) ? (w_sat - threshold) : '0;
      end
   end

endmodule

`default_nettype wire

// File: rtl/lif_neuron_array.sv
// lif_neuron_array: round-robin time-multiplexed array of LIF neurons sharing one update datapath.
// Rev 1.0
`default_nettype none

module lif_neuron_array
   import lif_pkg::*;
#(
   parameter int N_NEURONS      = DEF_N_NEURONS,
   parameter int V_WIDTH        = DEF_V_WIDTH,
   parameter int I_WIDTH        = DEF_I_WIDTH,
   parameter int LEAK_SHIFT     = DEF_LEAK_SHIFT,
   parameter int REFRAC_UPDATES = DEF_REFRAC_UPDATES
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              ena,
   input  logic [N_NEURONS*I_WIDTH-1:0]      isyn,
   input  logic [V_WIDTH-1:0]                threshold,
   input  logic                              reset_mode,
   output logic [N_NEURONS-1:0]              spike,
   output logic                              frame_done,
   output logic [clog2_min1(N_NEURONS)-1:0]  active_idx
);

   localparam int IDX_W   = clog2_min1(N_NEURONS);
   localparam int R_WIDTH = clog2_min1(REFRAC_UPDATES + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

   logic [V_WIDTH-1:0] v_q [N_NEURONS];
   logic [R_WIDTH-1:0] r_q [N_NEURONS];
   logic [N_NEURONS-1:0] spike_q;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               frame_done_q, frame_done_d;

   logic [I_WIDTH-1:0] w_isyn [N_NEURONS];
   logic [V_WIDTH-1:0] w_v_next;
   logic [R_WIDTH-1:0] w_r_next;
   logic               w_fire;

   for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_isyn
      assign w_isyn[gi] = isyn[gi*I_WIDTH +: I_WIDTH];
   end

   lif_update #(
      .V_WIDTH        (V_WIDTH),
      .I_WIDTH        (I_WIDTH),
      .LEAK_SHIFT     (LEAK_SHIFT),
      .REFRAC_UPDATES (REFRAC_UPDATES),
      .R_WIDTH        (R_WIDTH)
   ) u_update (
      .v          (v_q[idx_q]),
      .r          (r_q[idx_q]),
      .isyn_i     (w_isyn[idx_q]),
      .threshold  (threshold),
      .reset_mode (reset_mode),
      .v_next     (w_v_next),
      .r_next     (w_r_next),
      .fire       (w_fire)
   );

   always_comb begin
      idx_d        = idx_q;
      frame_done_d = 1'b0;
      if (ena) begin
         idx_d        = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
         frame_done_d = (idx_q == LAST_IDX);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_NEURONS; i++) begin
            v_q[i] <= '0;
            r_q[i] <= '0;
         end
         spike_q      <= '0;
         idx_q        <= '0;
         frame_done_q <= 1'b0;
      end else begin
         idx_q        <= idx_d;
         frame_done_q <= frame_done_d;
         if (ena) begin
            v_q[idx_q]     <= w_v_next;
            r_q[idx_q]     <= w_r_next;
            spike_q[idx_q] <= w_fire;
         end
      end
   end

   assign spike      = spike_q;
   assign frame_done = frame_done_q;
   assign active_idx = idx_q;

endmodule

`default_nettype wire

// File: tb/tb_lif_neuron_array.sv
// Directed bench for lif_neuron_array: default instance plus a no-refractory instance on shared inputs.
// Rev 1.0
`default_nettype none

module tb_lif_neuron_array;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ena;
   logic [23:0] isyn;
   logic [7:0]  threshold;
   logic        reset_mode;

   logic [2:0] spike, spike_nr;
   logic       fd, fd_nr;
   logic [1:0] aidx, aidx_nr;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   lif_neuron_array #(
      .N_NEURONS(3), .V_WIDTH(8), .I_WIDTH(8), .LEAK_SHIFT(1), .REFRAC_UPDATES(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .isyn(isyn), .threshold(threshold),
      .reset_mode(reset_mode), .spike(spike), .frame_done(fd), .active_idx(aidx)
   );

   lif_neuron_array #(
      .N_NEURONS(3), .V_WIDTH(8), .I_WIDTH(8), .LEAK_SHIFT(1), .REFRAC_UPDATES(0)
   ) dut_nr (
      .clk(clk), .rst_n(rst_n), .ena(ena), .isyn(isyn), .threshold(threshold),
      .reset_mode(reset_mode), .spike(spike_nr), .frame_done(fd_nr), .active_idx(aidx_nr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_isyn(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2);
      isyn = {a2, a1, a0};
   endtask

   // Called 1 time unit after an edge: async assert, check, release on the following negedge.
   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      #2;
      chk({tag, "_rst_spike"}, 32'(spike), 32'd0);
      chk({tag, "_rst_fd"},    32'(fd),    32'd0);
      chk({tag, "_rst_idx"},   32'(aidx),  32'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   logic [7:0] e_main, e_nr;
   logic [2:0] e_vec [6];

   initial begin
      rst_n = 1'b0; ena = 1'b0; isyn = '0; threshold = 8'd100; reset_mode = 1'b0;
      #12;
      chk("init_spike", 32'(spike), 32'd0);
      chk("init_fd",    32'(fd),    32'd0);
      chk("init_idx",   32'(aidx),  32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ena   = 1'b1;

      // Integrate and fire, reset-to-zero: 60,90,105F,R,R,60,90,105F
      set_isyn(8'd60, 8'd0, 8'd0);
      e_main = 8'b1000_0100;
      e_nr   = 8'b0010_0100;
      for (int u = 0; u < 8; u++) begin
         tick();
         chk($sformatf("if_main_u%0d", u + 1), 32'(spike[0]), 32'(e_main[u]));
         chk($sformatf("if_nr_u%0d", u + 1),   32'(spike_nr[0]), 32'(e_nr[u]));
         tick();
         tick();
      end

      // Subtract mode with refractory: residual is cleared while refractory
      do_reset("sub");
      reset_mode = 1'b1;
      for (int u = 0; u < 6; u++) begin
         tick();
         chk($sformatf("sub_main_u%0d", u + 1), 32'(spike[0]), 32'(e_main[u]));
         tick();
         tick();
      end

      // Subtract residual visible without refractory: 200F(v=100), then 50>=40 F, then 5<40
      do_reset("res");
      reset_mode = 1'b1; threshold = 8'd100; set_isyn(8'd200, 8'd0, 8'd0);
      tick();
      chk("res_nr_u1", 32'(spike_nr[0]), 32'd1);
      chk("res_main_u1", 32'(spike[0]), 32'd1);
      set_isyn(8'd0, 8'd0, 8'd0); threshold = 8'd40;
      tick(); tick(); tick();
      chk("res_nr_u2", 32'(spike_nr[0]), 32'd1);
      chk("res_main_u2_refrac", 32'(spike[0]), 32'd0);
      tick(); tick(); tick();
      chk("res_nr_u3", 32'(spike_nr[0]), 32'd0);

      // Same stimulus in zero mode: nothing left to fire on
      do_reset("zro");
      reset_mode = 1'b0; threshold = 8'd100; set_isyn(8'd200, 8'd0, 8'd0);
      tick();
      chk("zro_nr_u1", 32'(spike_nr[0]), 32'd1);
      set_isyn(8'd0, 8'd0, 8'd0); threshold = 8'd40;
      tick(); tick(); tick();
      chk("zro_nr_u2", 32'(spike_nr[0]), 32'd0);

      // Saturation: isyn1=255, threshold=255, subtract mode
      do_reset("sat");
      reset_mode = 1'b1; threshold = 8'd255; set_isyn(8'd0, 8'd255, 8'd0);
      e_main = 8'b0000_1001;
      for (int u = 0; u < 4; u++) begin
         tick();
         tick();
         chk($sformatf("sat_nr_u%0d", u + 1),   32'(spike_nr[1]), 32'd1);
         chk($sformatf("sat_main_u%0d", u + 1), 32'(spike[1]), 32'(e_main[u]));
         chk($sformatf("sat_n0_u%0d", u + 1),   32'(spike_nr[0]), 32'd0);
         tick();
      end

      // threshold = 0 fires every non-refractory update
      do_reset("th0");
      reset_mode = 1'b0; threshold = 8'd0; set_isyn(8'd0, 8'd0, 8'd0);
      tick();
      chk("th0_nr_u1", 32'(spike_nr[0]), 32'd1);
      chk("th0_main_u1", 32'(spike[0]), 32'd1);
      tick(); tick(); tick();
      chk("th0_nr_u2", 32'(spike_nr[0]), 32'd1);
      chk("th0_main_u2", 32'(spike[0]), 32'd0);

      // Frame sequencing and enable freeze
      do_reset("frm");
      threshold = 8'd100; reset_mode = 1'b0; set_isyn(8'd200, 8'd0, 8'd200);
      chk("frm_idx0", 32'(aidx), 32'd0);
      chk("frm_fd0",  32'(fd),   32'd0);
      tick(); chk("frm_idx1", 32'(aidx), 32'd1); chk("frm_fd1", 32'(fd), 32'd0);
      tick(); chk("frm_idx2", 32'(aidx), 32'd2); chk("frm_fd2", 32'(fd), 32'd0);
      tick(); chk("frm_idx3", 32'(aidx), 32'd0); chk("frm_fd3", 32'(fd), 32'd1);
      chk("frm_nr_fd3", 32'(fd_nr), 32'd1);
      tick(); chk("frm_idx4", 32'(aidx), 32'd1); chk("frm_fd4", 32'(fd), 32'd0);
      chk("frm_spk4", 32'(spike), 32'b100);
      ena = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk($sformatf("hold_idx_c%0d", c), 32'(aidx),  32'd1);
         chk($sformatf("hold_fd_c%0d", c),  32'(fd),    32'd0);
         chk($sformatf("hold_spk_c%0d", c), 32'(spike), 32'b100);
      end
      ena = 1'b1;
      tick(); chk("res_idx2", 32'(aidx), 32'd2); chk("res_spk_a", 32'(spike), 32'b100);
      tick(); chk("res_idx0", 32'(aidx), 32'd0); chk("res_fd", 32'(fd), 32'd1);
      chk("res_spk_b", 32'(spike), 32'b000);
      tick(); chk("res_idx1", 32'(aidx), 32'd1);

      // Reset mid-frame with active_idx non-zero
      do_reset("mid1");

      // Reach v0=90, r2=1 with spike1 and frame_done set, then reset asynchronously
      threshold = 8'd100; set_isyn(8'd60, 8'd60, 8'd200);
      tick(); tick(); tick(); tick();
      threshold = 8'd50;
      tick(); tick();
      chk("mid_pre_spk", 32'(spike), 32'b010);
      chk("mid_pre_fd",  32'(fd),    32'd1);
      do_reset("mid2");
      threshold = 8'd100; set_isyn(8'd60, 8'd0, 8'd200);
      tick();
      chk("mid_post_u1", 32'(spike[0]), 32'd0);
      tick(); tick();
      chk("mid_post_n2", 32'(spike), 32'b100);
      tick(); tick(); tick(); tick();
      chk("mid_post_u3", 32'(spike[0]), 32'd1);

      // Independence: isyn0=0, isyn1=60, isyn2=255
      do_reset("ind");
      threshold = 8'd100; reset_mode = 1'b0; set_isyn(8'd0, 8'd60, 8'd255);
      e_vec[0] = 3'b100; e_vec[1] = 3'b000; e_vec[2] = 3'b010;
      e_vec[3] = 3'b100; e_vec[4] = 3'b000; e_vec[5] = 3'b000;
      for (int f = 0; f < 6; f++) begin
         tick(); tick(); tick();
         chk($sformatf("ind_f%0d", f + 1), 32'(spike), 32'(e_vec[f]));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
